pwm_shadow_core: RTL and testbench



---
 rtl/pwm_shadow_core.sv | 153 +++++++++++++++
 tb/tb_pwm_shadow_core.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_shadow_core.sv
// Purpose : counter/comparator PWM with shadowed period/duty applied glitch-free at period wrap.
// Latency : pwm_out/pwm_out_l/period_tick are registered, one clk after the counter value that produced them.
// Backpressure: none; upd_strobe is always accepted, and a newer strobe overwrites an unapplied one.
//
// Ports:
//   clk, rst_n              PWM domain clock, async active-low reset
//   enable                  run enable (level); low holds counter at 0 and forces outputs low
//   upd_strobe              single-cycle capture request for period_in/duty_in
//   period_in, duty_in      new period (minus one) and high-time, stable while upd_strobe is high
//   pwm_out, pwm_out_l      registered high-side / complementary outputs
//   period_tick             one-cycle pulse the cycle after the wrap cycle
//   upd_pending             shadow values waiting for a period boundary
//   cnt_out                 current counter value
//
// Build option: define PWM_DEADTIME_EN to insert DEAD cycles of both-low dead time
// around every edge of the raw compare result.
module pwm_shadow_core #(
    parameter int WIDTH = 16,
    parameter int DEAD  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             upd_strobe,
    input  logic [WIDTH-1:0] period_in,
    input  logic [WIDTH-1:0] duty_in,
    output logic             pwm_out,
    output logic             pwm_out_l,
    output logic             period_tick,
    output logic             upd_pending,
    output logic [WIDTH-1:0] cnt_out
);

    // The dead counter is 8 bits wide; reject out-of-range settings at elaboration.
    if ((DEAD < 1) || (DEAD > 255)) begin : g_dead_range
        $error("pwm_shadow_core: DEAD must be in 1..255");
    end

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_period_act;
    logic [WIDTH-1:0] r_duty_act;
    logic [WIDTH-1:0] r_period_shd;
    logic [WIDTH-1:0] r_duty_shd;
    logic             r_upd_pending;
    logic             r_period_tick;
    logic             r_pwm;
    logic             r_pwm_l;

    logic             w_wrap;
    logic             w_apply;
    logic             w_cmp;

    assign w_wrap  = (r_cnt == r_period_act);
    // While disabled there is no waveform to protect, so pending values go live at once.
    assign w_apply = r_upd_pending & (~enable | w_wrap);
    assign w_cmp   = (r_cnt < r_duty_act);

    // Shadow capture and apply. A strobe coinciding with an apply lands in the shadow
    // registers after the old shadow contents have been copied, so pending stays set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period_shd  <= '0;
            r_duty_shd    <= '0;
            r_period_act  <= '0;
            r_duty_act    <= '0;
            r_upd_pending <= 1'b0;
        end else begin
            if (upd_strobe) begin
                r_period_shd <= period_in;
                r_duty_shd   <= duty_in;
            end
            if (w_apply) begin
                r_period_act <= r_period_shd;
                r_duty_act   <= r_duty_shd;
            end
            if (upd_strobe) begin
                r_upd_pending <= 1'b1;
            end else if (w_apply) begin
                r_upd_pending <= 1'b0;
            end
        end
    end

    // Counter never exceeds period_act, so the increment cannot overflow WIDTH bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_period_tick <= 1'b0;
        end else begin
            r_period_tick <= enable & w_wrap;
            if (!enable || w_wrap) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + WIDTH'(1);
            end
        end
    end

`ifdef PWM_DEADTIME_EN
    logic [7:0] r_dead;
    logic       r_cmp_q;
    logic [7:0] w_dead_nxt;
    logic       w_edge;

    assign w_edge = (w_cmp != r_cmp_q);

    // Any edge of the raw compare (re)loads the dead counter; outputs stay low until it drains.
    always_comb begin
        w_dead_nxt = r_dead;
        if (w_edge) begin
            w_dead_nxt = 8'(DEAD);
        end else if (r_dead != 8'd0) begin
            w_dead_nxt = r_dead - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dead  <= 8'd0;
            r_cmp_q <= 1'b0;
            r_pwm   <= 1'b0;
            r_pwm_l <= 1'b0;
        end else if (!enable) begin
            r_dead  <= 8'd0;
            r_cmp_q <= 1'b0;
            r_pwm   <= 1'b0;
            r_pwm_l <= 1'b0;
        end else begin
            r_dead  <= w_dead_nxt;
            r_cmp_q <= w_cmp;
            r_pwm   <= w_cmp & (w_dead_nxt == 8'd0);
            r_pwm_l <= ~w_cmp & (w_dead_nxt == 8'd0);
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm   <= 1'b0;
            r_pwm_l <= 1'b0;
        end else begin
            r_pwm   <= enable & w_cmp;
            r_pwm_l <= enable & ~w_cmp;
        end
    end
`endif

    assign pwm_out     = r_pwm;
    assign pwm_out_l   = r_pwm_l;
    assign period_tick = r_period_tick;
    assign upd_pending = r_upd_pending;
    assign cnt_out     = r_cnt;

endmodule

// File: tb/tb_pwm_shadow_core.sv
// Purpose : directed self-checking bench for pwm_shadow_core.
// Latency : samples outputs 1 time unit after each rising clk edge.
// Backpressure: n/a.
module tb_pwm_shadow_core;

    localparam int WIDTH = 16;
    localparam int DEAD  = 4;

    logic             clk;
    logic             rst_n;
    logic             enable;
    logic             upd_strobe;
    logic [WIDTH-1:0] period_in;
    logic [WIDTH-1:0] duty_in;
    logic             pwm_out;
    logic             pwm_out_l;
    logic             period_tick;
    logic             upd_pending;
    logic [WIDTH-1:0] cnt_out;

    int n_checks = 0;
    int n_errors = 0;

    pwm_shadow_core #(.WIDTH(WIDTH), .DEAD(DEAD)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .upd_strobe  (upd_strobe),
        .period_in   (period_in),
        .duty_in     (duty_in),
        .pwm_out     (pwm_out),
        .pwm_out_l   (pwm_out_l),
        .period_tick (period_tick),
        .upd_pending (upd_pending),
        .cnt_out     (cnt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_upd(input int p, input int d);
        upd_strobe = 1'b1;
        period_in  = WIDTH'(p);
        duty_in    = WIDTH'(d);
        step();
        upd_strobe = 1'b0;
    endtask

    // Starting from a sampled cnt_out of 0 with active period length plen and duty,
    // checks ncyc consecutive cycles of the free-running waveform.
    task automatic check_run(input int plen, input int duty, input int ncyc);
        for (int n = 1; n <= ncyc; n++) begin
            step();
            chk("cnt",   32'(cnt_out),     32'(n % plen));
            chk("pwm",   32'(pwm_out),     32'(((n - 1) % plen) < duty));
            chk("pwm_l", 32'(pwm_out_l),   32'(!(((n - 1) % plen) < duty)));
            chk("tick",  32'(period_tick), 32'((n % plen) == 0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b0;
        upd_strobe = 1'b0;
        period_in  = '0;
        duty_in    = '0;
        repeat (2) step();
        chk("rst_cnt",   32'(cnt_out),     32'd0);
        chk("rst_pwm",   32'(pwm_out),     32'd0);
        chk("rst_pwm_l", 32'(pwm_out_l),   32'd0);
        chk("rst_tick",  32'(period_tick), 32'd0);
        chk("rst_pend",  32'(upd_pending), 32'd0);
        rst_n = 1'b1;
        step();

`ifdef PWM_DEADTIME_EN
        pulse_upd(19, 10);
        chk("dt_pend", 32'(upd_pending), 32'd1);
        step();
        enable = 1'b1;
        // Raw compare high for cnt 0..9; 4-cycle gap, then each side high for 6 cycles.
        for (int n = 1; n <= 40; n++) begin
            step();
            chk("dt_hi", 32'(pwm_out),   32'((((n - 1) % 20) >= 4)  && (((n - 1) % 20) <= 9)));
            chk("dt_lo", 32'(pwm_out_l), 32'((((n - 1) % 20) >= 14) && (((n - 1) % 20) <= 19)));
        end
        enable = 1'b0;
        step();
        chk("dt_dis_hi", 32'(pwm_out),   32'd0);
        chk("dt_dis_lo", 32'(pwm_out_l), 32'd0);
        pulse_upd(19, 2);
        step();
        enable = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            step();
            chk("dt_short", 32'(pwm_out), 32'd0);
        end
`else
        // Period 0 after reset: wraps every cycle, tick continuous, output low.
        enable = 1'b1;
        check_run(1, 0, 4);

        // Configure while disabled: applied the cycle after pending rises.
        enable = 1'b0;
        step();
        chk("dis_tick", 32'(period_tick), 32'd0);
        chk("dis_cnt",  32'(cnt_out),     32'd0);
        chk("dis_pwm",  32'(pwm_out),     32'd0);
        pulse_upd(9, 3);
        chk("dis_pend_set", 32'(upd_pending), 32'd1);
        step();
        chk("dis_pend_clr", 32'(upd_pending), 32'd0);
        enable = 1'b1;
        check_run(10, 3, 20);

        // Mid-period update: old waveform finishes, new one starts after wrap.
        repeat (5) step();
        chk("mid_cnt5", 32'(cnt_out), 32'd5);
        pulse_upd(4, 2);
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) step();
            chk("mid_cnt",  32'(cnt_out),     32'(5 + k));
            chk("mid_pend", 32'(upd_pending), 32'd1);
            chk("mid_pwm",  32'(pwm_out),     32'd0);
        end
        step();
        chk("mid_wrap_cnt",  32'(cnt_out),     32'd0);
        chk("mid_wrap_pend", 32'(upd_pending), 32'd0);
        chk("mid_wrap_tick", 32'(period_tick), 32'd1);
        check_run(5, 2, 10);

        // Strobe on the wrap cycle with nothing pending: applies one period later.
        repeat (4) step();
        chk("wr_cnt4", 32'(cnt_out), 32'd4);
        pulse_upd(2, 1);
        chk("wr_cnt0", 32'(cnt_out),     32'd0);
        chk("wr_pend", 32'(upd_pending), 32'd1);
        chk("wr_tick", 32'(period_tick), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("wr_old_cnt",  32'(cnt_out),     32'(k));
            chk("wr_old_pend", 32'(upd_pending), 32'd1);
            chk("wr_old_pwm",  32'(pwm_out),     32'((k - 1) < 2));
        end
        step();
        chk("wr_apply_cnt",  32'(cnt_out),     32'd0);
        chk("wr_apply_pend", 32'(upd_pending), 32'd0);
        check_run(3, 1, 6);

        // Back-to-back strobes (last wins), then a strobe on the applying wrap cycle.
        pulse_upd(4, 1);
        chk("bb_cnt1", 32'(cnt_out),     32'd1);
        chk("bb_pend", 32'(upd_pending), 32'd1);
        pulse_upd(7, 7);
        chk("bb_cnt2", 32'(cnt_out), 32'd2);
        pulse_upd(9, 20);
        chk("bb_wrap_cnt",  32'(cnt_out),     32'd0);
        chk("bb_wrap_pend", 32'(upd_pending), 32'd1);
        chk("bb_wrap_tick", 32'(period_tick), 32'd1);
        check_run(8, 7, 8);
        chk("bb_pend_clr", 32'(upd_pending), 32'd0);
        // duty 20 > period 9: constant high.
        check_run(10, 20, 10);

        // Asynchronous reset mid-period discards the pending update.
        repeat (3) step();
        chk("ar_pwm_pre", 32'(pwm_out), 32'd1);
        pulse_upd(5, 5);
        chk("ar_pend_pre", 32'(upd_pending), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_pwm",   32'(pwm_out),     32'd0);
        chk("ar_pwm_l", 32'(pwm_out_l),   32'd0);
        chk("ar_pend",  32'(upd_pending), 32'd0);
        chk("ar_cnt",   32'(cnt_out),     32'd0);
        chk("ar_tick",  32'(period_tick), 32'd0);
        enable = 1'b0;
        #3;
        rst_n = 1'b1;
        repeat (2) step();
        chk("ar_pend_post", 32'(upd_pending), 32'd0);
        enable = 1'b1;
        check_run(1, 0, 3);

        // duty 0: constant low.
        enable = 1'b0;
        step();
        pulse_upd(9, 0);
        step();
        enable = 1'b1;
        check_run(10, 0, 20);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
